// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises nCS/SCK/MOSI into clk and assembles MSB-first words of width bits.
// Latency: data_valid/frame_error pulse sync_stages+2 clk after the raw nCS rise.
// Backpressure: none; each word is presented for one clk and held on data until the next good frame.
module spi_frame_rx #(
    parameter int width       = 24,
    parameter int sync_stages = 2
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             nCS,
    input  logic             SCK,
    input  logic             MOSI,
    output logic [width-1:0] data,
    output logic             data_valid,
    output logic             frame_error,
    output logic             busy
);

    localparam int CW = $clog2(width + 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(width);

    typedef enum logic [1:0] {IDLE, RECV, OVER} state_t;

    logic [sync_stages-1:0] ncs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   ncs_prev_q, sck_prev_q;
    logic                   started_q, armed_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [width-1:0]       shreg_q, shreg_d;
    logic                   done_ok_q, done_ok_d;
    logic                   done_err_q, done_err_d;
    logic [width-1:0]       data_q;
    logic                   data_valid_q, frame_error_q;

    logic ncs_s, sck_s, mosi_s;
    logic ncs_rise, ncs_fall, sck_rise;
    logic ovf;

    assign ncs_s  = ncs_sync_q[sync_stages-1];
    assign sck_s  = sck_sync_q[sync_stages-1];
    assign mosi_s = mosi_sync_q[sync_stages-1];

    assign ncs_rise = ncs_s & ~ncs_prev_q;
    assign ncs_fall = ~ncs_s & ncs_prev_q;
    assign sck_rise = sck_s & ~sck_prev_q;

    // Input synchronisers, reset to idle bus levels (nCS high, SCK/MOSI low).
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            ncs_sync_q  <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[sync_stages-2:0], nCS};
            sck_sync_q  <= {sck_sync_q[sync_stages-2:0], SCK};
            mosi_sync_q <= {mosi_sync_q[sync_stages-2:0], MOSI};
        end
    end

    // Edge-detect history, plus arming: a frame may only start once nCS has been
    // genuinely sampled high after reset, so a fall that happened during reset is ignored.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            ncs_prev_q <= 1'b1;
            sck_prev_q <= 1'b0;
            started_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            ncs_prev_q <= ncs_s;
            sck_prev_q <= sck_s;
            started_q  <= 1'b1;
            armed_q    <= armed_q | (started_q & ncs_sync_q[0]);
        end
    end

    // Frame state, bit counter, shift register and registered end-of-frame outcome.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            done_ok_q  <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            done_ok_q  <= done_ok_d;
            done_err_q <= done_err_d;
        end
    end

    // Next state: a same-cycle SCK rise is shifted and counted before the nCS-rise length check.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        done_ok_d  = 1'b0;
        done_err_d = 1'b0;
        ovf        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall && armed_q) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                if (sck_rise) begin
                    if (cnt_q == FULL_CNT) begin
                        ovf = 1'b1;
                    end else begin
                        shreg_d = {shreg_q[width-2:0], mosi_s};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (!ovf && cnt_d == FULL_CNT) begin
                        done_ok_d = 1'b1;
                    end else begin
                        done_err_d = 1'b1;
                    end
                end else if (ovf) begin
                    state_d = OVER;
                end
            end
            OVER: begin
                if (ncs_rise) begin
                    state_d    = IDLE;
                    done_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: publish the word and the one-clk status pulses.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            if (done_ok_q) begin
                data_q <= shreg_q;
            end
            data_valid_q  <= done_ok_q;
            frame_error_q <= done_err_q;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != IDLE);

endmodule
